// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encodings and the
// default operand/slice widths also used by the ALU.
package multicycle_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK-bit slice of the adder: a combinational ripple of full-adder cells.
// c_msb is the carry into the slice MSB, so the top slice can report signed
// overflow as c_msb ^ cout.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Ripple the carry through CHUNK full-adder cells, LSB first.
    always_comb begin
        logic c;
        // NOTE: blocking assignments here are intentional; c is a scratch
        // variable that must carry each cell's result into the next iteration.
        c     = cin;
        s     = '0;
        c_msb = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
// resolved one CHUNK-bit slice per clock with the carry held in a register,
// behind valid/ready handshakes on both sides.
// Optional feature: define MULTICYCLE_ADDER_CIN_EN to add an external carry-in
// port (in_cin), giving initial carry = in_sub ^ in_cin for chained words.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
`ifdef MULTICYCLE_ADDER_CIN_EN
    input  logic             in_cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("multicycle_adder: CHUNK (%0d) must be at least 1", CHUNK);
    end
    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("multicycle_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   merged;
    logic [CHUNK-1:0]   slice_s;
    logic               slice_cout;
    logic               slice_cmsb;
    logic               cin0;
    logic               accept;
    logic               last;
    logic               out_fire;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (state == ST_RUN) && (idx == LAST_IDX);
    assign out_fire = out_valid && out_ready;

`ifdef MULTICYCLE_ADDER_CIN_EN
    assign cin0 = in_sub ^ in_cin;
`else
    assign cin0 = in_sub;
`endif

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_reg[idx*CHUNK +: CHUNK]),
        .b     (b_reg[idx*CHUNK +: CHUNK]),
        .cin   (carry),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Full result as it will look once the current slice is written back.
    always_comb begin
        merged = acc;
        merged[idx*CHUNK +: CHUNK] = slice_s;
    end

    // Next-state logic: accept -> run NCHUNK slices -> hold until taken.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept)   next_state = ST_RUN;
            ST_RUN:  if (last)     next_state = ST_DONE;
            ST_DONE: if (out_fire) next_state = ST_IDLE;
            default:               next_state = ST_IDLE;
        endcase
    end

    // Control state, slice counter, carry and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                idx   <= '0;
                carry <= cin0;
            end else if (state == ST_RUN) begin
                idx   <= idx + 1'b1;
                carry <= slice_cout;
            end
            if (last) begin
                sum       <= merged;
                cout      <= slice_cout;
                overflow  <= slice_cmsb ^ slice_cout;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Operand capture and partial-result accumulator.
    // NOTE: these datapath registers are deliberately not reset; they are
    // always written before being read, and the control path discards them.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
        end
        if (state == ST_RUN) begin
            acc[idx*CHUNK +: CHUNK] <= slice_s;
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed self-checking bench for multicycle_adder.
module tb_multicycle_adder;

    localparam int WIDTH = 32;
`ifdef MULTICYCLE_ADDER_CIN_EN
    localparam int CHUNK = 32;
`else
    localparam int CHUNK = 8;
`endif
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_sub = 1'b0;
`ifdef MULTICYCLE_ADDER_CIN_EN
    logic             in_cin = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    multicycle_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
`ifdef MULTICYCLE_ADDER_CIN_EN
        .in_cin    (in_cin),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one operation, wait for the result and check latency and value.
    // Operands are scrambled right after the accept edge to show they are captured.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic cin,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int cycles;
        cycles = 0;
        while (!in_ready && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
`ifdef MULTICYCLE_ADDER_CIN_EN
        in_cin   = cin;
`else
        if (cin) $display("note: %s asks for carry-in without the feature", tag);
`endif
        tick();
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h1357_9BDF;
        in_sub   = ~sub;
        cycles   = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'(NCHUNK));
        check({tag, "_sum"},     64'(sum),      64'(exp_sum));
        check({tag, "_cout"},    64'(cout),     64'(exp_cout));
        check({tag, "_ovf"},     64'(overflow), 64'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drained"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [WIDTH-1:0] held_sum;

        // Reset state.
        #12;
        check("rst_during_in_ready", 64'(in_ready), 64'd1);
        check("rst_during_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_outputs", 64'({in_ready, out_valid, cout, overflow}), 64'b1000);
        check("rst_sum", 64'(sum), 64'd0);

        // Basic add with carry across a slice boundary.
        run_op("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("add_mix",   32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0);

        // Signed overflow and unsigned wrap.
        run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        // Subtraction, borrow and overflow.
        run_op("sub_5_7",   32'd5,         32'd7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_7_5",   32'd7,         32'd5,         1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
        run_op("sub_min_1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: result held in DONE, new in_valid ignored.
        in_valid = 1'b1;
        in_a     = 32'h0000_1000;
        in_b     = 32'h0000_0234;
        in_sub   = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (NCHUNK) tick();
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_sum", 64'(sum), 64'h0000_1234);
        held_sum = sum;
        in_valid = 1'b1;
        in_a     = 32'h0000_0005;
        in_b     = 32'h0000_0005;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 64'({out_valid, in_ready}), 64'b10);
            check("bp_hold_sum", 64'({cout, overflow, sum}), 64'({2'b00, held_sum}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 64'({out_valid, in_ready}), 64'b01);
        check("bp_sum_kept", 64'(sum), 64'h0000_1234);
        run_op("bp_next",   32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);

        // Reset in the middle of an operation.
        in_valid = 1'b1;
        in_a     = 32'h0000_0009;
        in_b     = 32'h0000_0009;
        in_sub   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_release", 64'({in_ready, out_valid}), 64'b10);
        repeat (NCHUNK + 1) tick();
        check("mid_rst_no_result", 64'(out_valid), 64'd0);
        run_op("after_rst", 32'd3,         32'd4,         1'b0, 1'b0, 32'd7,         1'b0, 1'b0);

`ifdef MULTICYCLE_ADDER_CIN_EN
        run_op("cin_add",   32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 32'd0,         1'b1, 1'b0);
        run_op("cin_sub",   32'd5,         32'd3,         1'b1, 1'b1, 32'd1,         1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
